// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: synchronizes halls, samples rotor position at PWM
// boundaries, drives phase selects and duty, and flags bad hall codes and stall.
module bldc_commutator #(
  parameter int          STALL_CNT  = 1024,
  parameter logic [10:0] BRAKE_DUTY = 11'h600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        brake_n,
  input  logic [11:0] drv_mag,
  input  logic        PWM_synch,
  output logic [1:0]  selGrn,
  output logic [1:0]  selYlw,
  output logic [1:0]  selBlu,
  output logic [10:0] duty,
  output logic        hall_err,
  output logic        stalled
);

  localparam int             CW        = $clog2(STALL_CNT + 1);
  localparam logic [CW-1:0]  STALL_MAX = CW'(STALL_CNT);
  localparam logic [5:0]     SEL_BRAKE = 6'b11_11_11;

  logic [2:0]    r_sync1, r_sync2;
  logic [2:0]    r_rot;
  logic          r_primed;
  logic [CW-1:0] r_cnt;
  logic          r_upd;
  logic          r_brake;
  logic [9:0]    r_mag;

  logic [5:0]    w_tab;
  logic          w_inv;

  // Capture stage: everything the output stage needs is frozen on the
  // PWM_synch edge, so mid-period input changes wait for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_rot    <= '0;
      r_primed <= 1'b0;
      r_cnt    <= '0;
      r_upd    <= 1'b0;
      r_brake  <= 1'b0;
      r_mag    <= '0;
    end else begin
      r_sync1 <= {hallGrn, hallYlw, hallBlu};
      r_sync2 <= r_sync1;
      r_upd   <= PWM_synch;
      if (PWM_synch) begin
        r_rot    <= r_sync2;
        r_primed <= 1'b1;
        r_brake  <= ~brake_n;
        r_mag    <= drv_mag[11:2];
        if (r_sync2 != r_rot)
          r_cnt <= '0;
        else if (r_cnt != STALL_MAX)
          r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_tab = 6'b00_00_00;
    w_inv = 1'b0;
    case (r_rot)
      3'b101:  w_tab = 6'b10_01_00;
      3'b100:  w_tab = 6'b10_00_01;
      3'b110:  w_tab = 6'b00_10_01;
      3'b010:  w_tab = 6'b01_10_00;
      3'b011:  w_tab = 6'b01_00_10;
      3'b001:  w_tab = 6'b00_01_10;
      default: w_inv = 1'b1;
    endcase
  end

  // Output stage: one clk after capture. hall_err is gated by primed so the
  // reset value of r_rot (000) is never reported.
  always_ff @(posedge clk) begin
    if (rst) begin
      {selGrn, selYlw, selBlu} <= '0;
      duty     <= '0;
      hall_err <= 1'b0;
      stalled  <= 1'b0;
    end else if (r_upd) begin
      {selGrn, selYlw, selBlu} <= r_brake ? SEL_BRAKE : w_tab;
      duty     <= r_brake ? BRAKE_DUTY : (11'h400 + {1'b0, r_mag});
      hall_err <= r_primed & w_inv;
      stalled  <= (r_cnt == STALL_MAX);
    end
  end

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed-vector bench for bldc_commutator; expectations are queued by the
// stimulus and popped by a monitor one clk after each PWM boundary.
module tb_bldc_commutator;

  logic        clk = 1'b0;
  logic        rst;
  logic        hallGrn, hallYlw, hallBlu;
  logic        brake_n;
  logic [11:0] drv_mag;
  logic        PWM_synch;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic [10:0] duty;
  logic        hall_err, stalled;

  bldc_commutator #(.STALL_CNT(4), .BRAKE_DUTY(11'h600)) dut (
    .clk(clk), .rst(rst),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
    .brake_n(brake_n), .drv_mag(drv_mag), .PWM_synch(PWM_synch),
    .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
    .duty(duty), .hall_err(hall_err), .stalled(stalled)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  sel;
    logic [10:0] duty;
    logic        err;
    logic        stall;
    logic [95:0] tag;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_chk = 0;
  int   n_pass = 0;
  event snap_ev;
  bit   p1 = 1'b0, p2 = 1'b0;

  task automatic check_one();
    exp_t e;
    logic [5:0] s;
    n_chk++;
    if (q.size() == 0) begin
      $display("FAIL unexpected_output: no queued expectation at %0t", $time);
      return;
    end
    e = q.pop_front();
    s = {selGrn, selYlw, selBlu};
    if (s === e.sel && duty === e.duty && hall_err === e.err && stalled === e.stall)
      n_pass++;
    else
      $display("FAIL %s: got sel=%b duty=%h err=%b stall=%b, want sel=%b duty=%h err=%b stall=%b",
               e.tag, s, duty, hall_err, stalled, e.sel, e.duty, e.err, e.stall);
  endtask

  // Monitor: outputs are due one clk after the clk where PWM_synch was high.
  always @(posedge clk) begin
    p1 <= PWM_synch;
    p2 <= p1;
  end
  always @(negedge clk) if (p2) check_one();
  always @(snap_ev) check_one();

  // Outputs must equal the previously settled values right now.
  task automatic snap(input logic [95:0] tag);
    exp_t e;
    e = last;
    e.tag = tag;
    q.push_back(e);
    -> snap_ev;
  endtask

  // Set halls, confirm outputs hold mid-period, then pulse a boundary.
  task automatic pulse(input logic [2:0] code, input logic [5:0] sel, input logic [10:0] d,
                       input logic err, input logic st, input logic [95:0] tag);
    exp_t e;
    @(negedge clk);
    {hallGrn, hallYlw, hallBlu} = code;
    @(negedge clk);
    snap("hold");
    repeat (2) @(negedge clk);
    e.sel = sel; e.duty = d; e.err = err; e.stall = st; e.tag = tag;
    q.push_back(e);
    last = e;
    PWM_synch = 1'b1;
    @(negedge clk);
    PWM_synch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; {hallGrn, hallYlw, hallBlu} = 3'b000;
    brake_n = 1'b1; drv_mag = 12'h800; PWM_synch = 1'b0;
    last = '0;
    repeat (2) @(negedge clk);
    snap("reset");
    rst = 1'b0;

    // six-step sweep; each pulse also checks outputs held while halls moved
    pulse(3'b101, 6'b10_01_00, 11'h600, 1'b0, 1'b0, "s101");
    pulse(3'b100, 6'b10_00_01, 11'h600, 1'b0, 1'b0, "s100");
    pulse(3'b110, 6'b00_10_01, 11'h600, 1'b0, 1'b0, "s110");
    pulse(3'b010, 6'b01_10_00, 11'h600, 1'b0, 1'b0, "s010");
    pulse(3'b011, 6'b01_00_10, 11'h600, 1'b0, 1'b0, "s011");
    pulse(3'b001, 6'b00_01_10, 11'h600, 1'b0, 1'b0, "s001");

    // brake mid-period: repeated code 001 counts 1, then 2
    @(negedge clk); brake_n = 1'b0;
    snap("brk_mid");
    pulse(3'b001, 6'b11_11_11, 11'h600, 1'b0, 1'b0, "brake");
    @(negedge clk); brake_n = 1'b1;
    snap("brk_rel_mid");
    pulse(3'b001, 6'b00_01_10, 11'h600, 1'b0, 1'b0, "brk_rel");

    // invalid hall codes, plain and under brake
    pulse(3'b111, 6'b00_00_00, 11'h600, 1'b1, 1'b0, "inv111");
    pulse(3'b110, 6'b00_10_01, 11'h600, 1'b0, 1'b0, "rec110a");
    pulse(3'b000, 6'b00_00_00, 11'h600, 1'b1, 1'b0, "inv000");
    pulse(3'b110, 6'b00_10_01, 11'h600, 1'b0, 1'b0, "rec110b");
    @(negedge clk); brake_n = 1'b0;
    pulse(3'b111, 6'b11_11_11, 11'h600, 1'b1, 1'b0, "brk_inv");
    @(negedge clk); brake_n = 1'b1;

    // stall with STALL_CNT=4: change, then repeats 1..5
    pulse(3'b011, 6'b01_00_10, 11'h600, 1'b0, 1'b0, "stl_c0");
    pulse(3'b011, 6'b01_00_10, 11'h600, 1'b0, 1'b0, "stl_c1");
    pulse(3'b011, 6'b01_00_10, 11'h600, 1'b0, 1'b0, "stl_c2");
    pulse(3'b011, 6'b01_00_10, 11'h600, 1'b0, 1'b0, "stl_c3");
    pulse(3'b011, 6'b01_00_10, 11'h600, 1'b0, 1'b1, "stl_c4");
    pulse(3'b011, 6'b01_00_10, 11'h600, 1'b0, 1'b1, "stl_sat");
    pulse(3'b001, 6'b00_01_10, 11'h600, 1'b0, 1'b0, "stl_clr");

    // duty extremes
    drv_mag = 12'h000;
    pulse(3'b001, 6'b00_01_10, 11'h400, 1'b0, 1'b0, "duty_min");
    drv_mag = 12'hFFF;
    pulse(3'b001, 6'b00_01_10, 11'h7FF, 1'b0, 1'b0, "duty_max");

    // reset mid-period, then outputs stay 0 until the next boundary
    @(negedge clk); rst = 1'b1;
    last = '0;
    @(negedge clk);
    snap("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    snap("rst_post");
    pulse(3'b001, 6'b00_01_10, 11'h7FF, 1'b0, 1'b0, "post_rst");

    repeat (4) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      $display("FAIL %s: expected output never observed", e.tag);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
